// File: rtl/generador_patrones_lcd.sv
// generador_patrones_lcd
//   LCD test-pattern generator placed between the timing generator and the RGB pins.
//   Four modes: colour bars, grey ramp, checkerboard and scrolling colour bars.
//   Two-stage registered pipeline with one pixel per clock. Mode and scroll offset
//   change only at frame boundaries, so a frame never mixes two modes.
// Ports
//   clk          pixel clock
//   reset        synchronous, active-high
//   columna      current column (COL_W bits)
//   fila         current row (ROW_W bits)
//   pixel_en     columna/fila valid this cycle
//   fin_cuadro   one-cycle end-of-frame pulse
//   modo         requested mode: 0 bars, 1 grey, 2 checker, 3 scroll
//   R, G, B      registered pixel colour (COLOR_W bits each)
//   pixel_valido R/G/B correspond to a pixel_en=1 input two cycles earlier
//   cuadro_cnt   16-bit wrapping frame counter
module generador_patrones_lcd #(
    parameter int unsigned H_ACTIVE     = 1056,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned NUM_BARS     = 8,
    parameter int unsigned COLOR_W      = 8,
    parameter int unsigned COL_W        = 11,
    parameter int unsigned ROW_W        = 10,
    parameter int unsigned CHECKER_LOG2 = 5,
    parameter int unsigned SCROLL_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COL_W-1:0]   columna,
    input  logic [ROW_W-1:0]   fila,
    input  logic               pixel_en,
    input  logic               fin_cuadro,
    input  logic [1:0]         modo,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               pixel_valido,
    output logic [15:0]        cuadro_cnt
);

    localparam int unsigned BAR_W     = H_ACTIVE / NUM_BARS;
    localparam int unsigned BAR_IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

    localparam logic [COL_W:0] H_ACT_W = (COL_W + 1)'(H_ACTIVE);
    localparam logic [ROW_W:0] V_ACT_W = (ROW_W + 1)'(V_ACTIVE);
    localparam logic [COLOR_W-1:0] CH_ON = '1;

    // ------------------------------------------------------------------
    // Frame-level state: updated only on fin_cuadro
    // ------------------------------------------------------------------
    logic [1:0]       modo_activo_q;
    logic [COL_W-1:0] despl_q;
    logic [COL_W-1:0] despl_d;
    logic [15:0]      cuadro_cnt_q;
    logic [COL_W:0]   despl_sum;

    always_comb begin
        despl_sum = {1'b0, despl_q} + (COL_W + 1)'(SCROLL_STEP);
        despl_d   = (despl_sum >= H_ACT_W) ? COL_W'(despl_sum - H_ACT_W) : COL_W'(despl_sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            modo_activo_q <= 2'd0;
            despl_q       <= '0;
            cuadro_cnt_q  <= 16'd0;
        end else if (fin_cuadro) begin
            modo_activo_q <= modo;
            despl_q       <= despl_d;
            cuadro_cnt_q  <= cuadro_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: visibility, effective column and checker bit
    // ------------------------------------------------------------------
    logic             activo;
    logic [COL_W:0]   col_sum;
    logic [COL_W-1:0] col_scr;
    logic [COL_W-1:0] col_eff;
    logic             chk;

    logic             v1_q;
    logic             vis1_q;
    logic [1:0]       modo1_q;
    logic [COL_W-1:0] col1_q;
    logic             chk1_q;

    always_comb begin
        activo  = ({1'b0, columna} < H_ACT_W) && ({1'b0, fila} < V_ACT_W);
        // columna and despl are both below H_ACTIVE, so one subtract is enough
        col_sum = {1'b0, columna} + {1'b0, despl_q};
        col_scr = (col_sum >= H_ACT_W) ? COL_W'(col_sum - H_ACT_W) : COL_W'(col_sum);
        col_eff = (modo_activo_q == 2'd3) ? col_scr : columna;
        chk     = columna[CHECKER_LOG2] ^ fila[CHECKER_LOG2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q    <= 1'b0;
            vis1_q  <= 1'b0;
            modo1_q <= 2'd0;
            col1_q  <= '0;
            chk1_q  <= 1'b0;
        end else begin
            v1_q    <= pixel_en;
            vis1_q  <= pixel_en & activo;
            // mode travels with the pixel so a frame switch never retints in-flight pixels
            modo1_q <= modo_activo_q;
            col1_q  <= col_eff;
            chk1_q  <= chk;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: bar index, colour lookup and output registers
    // ------------------------------------------------------------------
    logic [COLOR_W-1:0] grey_lut [NUM_BARS];

    for (genvar gi = 0; gi < NUM_BARS; gi++) begin : g_grey
        localparam int unsigned GREY_VAL = (gi * (2 ** COLOR_W - 1)) / (NUM_BARS - 1);
        assign grey_lut[gi] = COLOR_W'(GREY_VAL);
    end

    logic [BAR_IDX_W-1:0] bar;
    logic [2:0]           lut_idx;
    logic [COLOR_W-1:0]   r_d, g_d, b_d;
    logic [COLOR_W-1:0]   r_q, g_q, b_q;
    logic                 valido_q;

    always_comb begin
        // Thresholds rise monotonically, so the last one exceeded is the bar;
        // a column equal to a threshold stays in the lower bar.
        bar = '0;
        for (int unsigned i = 1; i < NUM_BARS; i++) begin
            if ({1'b0, col1_q} > (COL_W + 1)'(i * BAR_W)) begin
                bar = BAR_IDX_W'(i);
            end
        end
        lut_idx = 3'(bar);

        r_d = '0;
        g_d = '0;
        b_d = '0;
        case (modo1_q)
            2'd1: begin
                r_d = grey_lut[bar];
                g_d = grey_lut[bar];
                b_d = grey_lut[bar];
            end
            2'd2: begin
                r_d = chk1_q ? '0 : CH_ON;
                g_d = chk1_q ? '0 : CH_ON;
                b_d = chk1_q ? '0 : CH_ON;
            end
            default: begin
                // White, yellow, cyan, green, magenta, red, blue, black:
                // R off for idx bit1, G off for idx bit2, B off for idx bit0.
                r_d = lut_idx[1] ? '0 : CH_ON;
                g_d = lut_idx[2] ? '0 : CH_ON;
                b_d = lut_idx[0] ? '0 : CH_ON;
            end
        endcase

        if (!vis1_q) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            valido_q <= 1'b0;
        end else begin
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            valido_q <= v1_q;
        end
    end

    assign R            = r_q;
    assign G            = g_q;
    assign B            = b_q;
    assign pixel_valido = valido_q;
    assign cuadro_cnt   = cuadro_cnt_q;

endmodule
